// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: default bus widths and memory-port ownership encoding.
package riscv_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_IF,
    OWN_DM
  } owner_e;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Single-port RAM arbiter between fetch (IF) and load/store (DM): data-first priority,
// bounded DM streak against fetch starvation, read data returned one cycle after grant.
module riscv_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                dm_req_i,
  input  logic                dm_we_i,
  input  logic [DATA_W/8-1:0] dm_be_i,
  input  logic [ADDR_W-1:0]   dm_addr_i,
  input  logic [DATA_W-1:0]   dm_wdata_i,
  output logic                dm_gnt_o,
  output logic                dm_rvalid_o,
  output logic [DATA_W-1:0]   dm_rdata_o,
  output logic                mem_en_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stall_o
);

  localparam logic [3:0] SMAX = 4'(STREAK_MAX);

  owner_e     owner_q;
  logic       we_q;
  logic [3:0] streak_q;
  logic       at_max;

  assign at_max = (streak_q == SMAX);

  always_comb begin
    if_gnt_o    = if_req_i & (~dm_req_i | at_max);
    dm_gnt_o    = dm_req_i & ~if_gnt_o;
    mem_en_o    = if_gnt_o | dm_gnt_o;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (if_gnt_o) begin
      mem_be_o   = '1;
      mem_addr_o = if_addr_i;
    end else if (dm_gnt_o) begin
      mem_we_o    = dm_we_i;
      mem_be_o    = dm_be_i;
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
    end
    stall_o = (if_req_i & ~if_gnt_o) | (dm_req_i & ~dm_gnt_o);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= OWN_IDLE;
      we_q     <= 1'b0;
      streak_q <= '0;
    end else begin
      if (if_gnt_o)      owner_q <= OWN_IF;
      else if (dm_gnt_o) owner_q <= OWN_DM;
      else               owner_q <= OWN_IDLE;
      we_q <= dm_gnt_o & dm_we_i;
      // Streak only measures how long a waiting fetch has been passed over.
      if (!if_req_i || if_gnt_o)  streak_q <= '0;
      else if (dm_gnt_o && !at_max) streak_q <= streak_q + 4'd1;
    end
  end

  always_comb begin
    if_rvalid_o = (owner_q == OWN_IF);
    dm_rvalid_o = (owner_q == OWN_DM);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    dm_rdata_o  = (dm_rvalid_o && !we_q) ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Randomized bench for riscv_mem_arbiter with directed scenarios and a wait-length/word-array
// reference model of arbitration and memory contents.
module tb_riscv_mem_arbiter;

  localparam int unsigned SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we, stall;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STREAK_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .stall_o(stall)
  );

  always #5 clk = ~clk;

  logic [31:0] ram     [4096];
  logic [31:0] ref_mem [4096];

  // RAM reloads from the reference image while reset is held.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) ram[i] <= ref_mem[i];
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= ram[mem_addr[13:2]];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: how many cycles the current fetch has been passed over,
  // and the response due next cycle (0 none, 1 fetch, 2 data).
  int          wait_cnt;
  int          pend_owner;
  logic [31:0] pend_data;
  logic        last_if_gnt, last_dm_gnt, seen_if_gnt, seen_stall;

  function automatic int unsigned widx(input logic [31:0] a);
    return int'(a[13:2]);
  endfunction

  task automatic step();
    logic e_if, e_dm, e_stall;
    #1;
    e_if    = if_req && (!dm_req || wait_cnt >= int'(SMAX));
    e_dm    = dm_req && !e_if;
    e_stall = (if_req && !e_if) || (dm_req && !e_dm);
    chk("if_gnt", {31'b0, if_gnt}, {31'b0, e_if});
    chk("dm_gnt", {31'b0, dm_gnt}, {31'b0, e_dm});
    chk("stall", {31'b0, stall}, {31'b0, e_stall});
    chk("mem_en", {31'b0, mem_en}, {31'b0, e_if | e_dm});
    if (e_if) begin
      chk("mem_addr_if", mem_addr, if_addr);
      chk("mem_we_if", {31'b0, mem_we}, 32'd0);
      chk("mem_be_if", {28'b0, mem_be}, 32'hF);
    end else if (e_dm) begin
      chk("mem_addr_dm", mem_addr, dm_addr);
      chk("mem_we_dm", {31'b0, mem_we}, {31'b0, dm_we});
      if (dm_we) chk("mem_wdata", mem_wdata, dm_wdata);
    end else begin
      chk("mem_addr_idle", mem_addr, 32'd0);
    end
    chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, pend_owner == 1});
    chk("if_rdata", if_rdata, (pend_owner == 1) ? pend_data : 32'd0);
    chk("dm_rvalid", {31'b0, dm_rvalid}, {31'b0, pend_owner == 2});
    chk("dm_rdata", dm_rdata, (pend_owner == 2) ? pend_data : 32'd0);
    seen_if_gnt = if_gnt;
    seen_stall  = stall;
    if (e_if) begin
      pend_owner = 1;
      pend_data  = ref_mem[widx(if_addr)];
    end else if (e_dm) begin
      pend_owner = 2;
      if (dm_we) begin
        for (int b = 0; b < 4; b++)
          if (dm_be[b]) ref_mem[widx(dm_addr)][8*b +: 8] = dm_wdata[8*b +: 8];
        pend_data = 32'd0;
      end else begin
        pend_data = ref_mem[widx(dm_addr)];
      end
    end else begin
      pend_owner = 0;
      pend_data  = 32'd0;
    end
    if (!if_req || e_if) wait_cnt = 0;
    else                 wait_cnt++;
    last_if_gnt = e_if;
    last_dm_gnt = e_dm;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    wait_cnt = 0; pend_owner = 0; pend_data = 0; last_if_gnt = 0; last_dm_gnt = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = $urandom;
    ref_mem[1]     = 32'hFE01_0113;
    ref_mem[12'h801] = 32'h1122_3344;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rst_dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);

    // Fetch only
    if_req = 1; if_addr = 32'h0000_0004;
    step();
    idle_inputs();
    chk("fetch_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("fetch_rdata", if_rdata, 32'hFE01_0113);
    step();

    // Store then load
    dm_req = 1; dm_we = 1; dm_be = 4'hF; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
    step();
    dm_we = 0; dm_be = 0; dm_wdata = 0;
    chk("store_rvalid", {31'b0, dm_rvalid}, 32'd1);
    chk("store_rdata", dm_rdata, 32'd0);
    step();
    idle_inputs();
    chk("load_rvalid", {31'b0, dm_rvalid}, 32'd1);
    chk("load_rdata", dm_rdata, 32'hDEAD_BEEF);
    step();

    // Byte store then load
    dm_req = 1; dm_we = 1; dm_be = 4'h2; dm_addr = 32'h2004; dm_wdata = 32'h0000_AB00;
    step();
    dm_we = 0; dm_be = 0; dm_wdata = 0;
    step();
    idle_inputs();
    chk("byte_load", dm_rdata, 32'h1122_AB44);
    step();

    // Contention: DM x4 then IF, repeating
    for (int i = 0; i < 15; i++) begin
      if_req = 1; if_addr = 32'h0; dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
      step();
      chk("contend_pat", {31'b0, seen_if_gnt}, {31'b0, (i % 5) == 4});
      chk("contend_stall", {31'b0, seen_stall}, 32'd1);
    end
    idle_inputs();
    step();

    // Reset the cycle after a load grant
    dm_req = 1; dm_addr = 32'h2000;
    step();
    idle_inputs();
    reset = 1'b1;
    #1;
    chk("midrst_rvalid", {31'b0, dm_rvalid}, 32'd0);
    pend_owner = 0; pend_data = 0; wait_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("midrst_after", {31'b0, dm_rvalid}, 32'd0);
    if_req = 1; dm_req = 1; dm_addr = 32'h2000;
    step();
    chk("midrst_streak0", {31'b0, seen_if_gnt}, 32'd0);
    idle_inputs();
    step();

    // Randomized traffic; requesters hold until granted
    for (int n = 0; n < 500; n++) begin
      if (!if_req || last_if_gnt) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = {$urandom_range(0, 7), 2'b00};
      end
      if (!dm_req || last_dm_gnt) begin
        dm_req   = ($urandom_range(0, 99) < 60);
        dm_we    = $urandom_range(0, 1) == 1;
        dm_be    = 4'($urandom_range(1, 15));
        dm_addr  = 32'h2000 + 32'($urandom_range(0, 7)) * 4;
        dm_wdata = $urandom;
      end
      step();
    end
    idle_inputs();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
